// File: rtl/seven_seg_scan_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyphs and idle encodings.
package seven_seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic       AN_OFF  = 1'b1;

  // Active-high {a,b,c,d,e,f,g,dp}; entry 0 sits in the least significant byte.
  localparam logic [15:0][7:0] HEX_PAT = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  function automatic logic [7:0] hex_pattern(input logic [3:0] nib);
    return HEX_PAT[nib];
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Load/display bundle between the datapath (master) and the scan driver (slave).
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  // load is a single-cycle strobe with no back-pressure: the driver captures
  // value_in/dp_in on every rising edge where load=1, so holding it recaptures.
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank_lz;
  logic                      en;
  logic [7:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output load, value_in, dp_in, blank_lz, en,
    input  seg, an, frame_done
  );

  modport slave (
    input  load, value_in, dp_in, blank_lz, en,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational nibble-to-glyph decoder producing active-low segment drive.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = ~(hex_pattern(nibble) | {7'b0, dp});

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode display driver: slot/digit counters, held value,
// leading-zero blanking and registered seg/an/frame_done outputs.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_scan_if.slave bus
);

  localparam int CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DRIVE_LEN = REFRESH_DIV - GAP_CYCLES;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    nz_above;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [7:0]              cur_seg;
  logic                    drive;
  logic                    show;
  logic                    slot_end;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_done_q;

  // A digit is blanked when it and every more-significant nibble are zero.
  always_comb begin
    lz_blank = '0;
    nz_above = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      nz_above    = nz_above | (value_q[4*i +: 4] != 4'h0);
      lz_blank[i] = ~nz_above;
    end
  end

  assign cur_nib  = value_q[4*int'(idx) +: 4];
  assign cur_dp   = dp_q[idx];
  assign drive    = ({1'b0, cnt} < (CW+1)'(DRIVE_LEN));
  assign show     = drive & bus.en & ~(bus.blank_lz & lz_blank[idx]);
  assign slot_end = (cnt == CNT_MAX);

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dp_q    <= '0;
    end else if (bus.load) begin
      value_q <= bus.value_in;
      dp_q    <= bus.dp_in;
    end
  end

  // Outputs show the (idx, cnt) state that was current before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      an_q         <= {NUM_DIGITS{AN_OFF}};
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= show ? cur_seg : SEG_OFF;
      an_q         <= show ? ~(NUM_DIGITS'(1) << idx) : {NUM_DIGITS{AN_OFF}};
      frame_done_q <= slot_end & (idx == IDX_MAX);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan (4 digits, 8-cycle slots, 2 gap cycles): vector table,
// corner-case sequences and randomized traffic against a frame-position model.
module tb_seven_seg_scan;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GAP   = 2;
  localparam int FRAME = N * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] pat [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Model: edges since reset release fix the frame position; mv/mdp are the held word.
  int          edges;
  logic [15:0] mv;
  logic [3:0]  mdp;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    logic [15:0] exp_an;
    logic [31:0] exp_seg;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict from frame position and held word, advance, compare at edge+1.
  task automatic tick();
    int         pos, d, c;
    logic [3:0] ea;
    logic [7:0] es;
    logic [3:0] nib;
    logic       ef, blanked;
    pos     = edges % FRAME;
    d       = pos / DIV;
    c       = pos % DIV;
    nib     = 4'(mv >> (4 * d));
    blanked = bus.blank_lz && (d > 0) && ((mv >> (4 * d)) == 16'h0);
    ea      = 4'hF;
    es      = 8'hFF;
    if (bus.en && (c < DIV - GAP) && !blanked) begin
      ea[d] = 1'b0;
      es    = ~(pat[nib] | {7'b0, mdp[d]});
    end
    ef = (pos == FRAME - 1);
    @(posedge clk);
    edges++;
    if (bus.load) begin
      mv  = bus.value_in;
      mdp = bus.dp_in;
    end
    #1;
    chk("model_an", 32'(bus.an), 32'(ea));
    chk("model_seg", 32'(bus.seg), 32'(es));
    chk("model_frame_done", 32'(bus.frame_done), 32'(ef));
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      tick();
      seen = bus.frame_done;
    end
    chk("frame_seen", 32'(seen), 32'd1);
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, c, period, pulses;
    bit seen;

    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, 16'h7BDE, 32'h9F251171};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, 16'hFFFE, 32'hFFFFFF49};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'hFFFE, 32'hFFFFFF03};
    vecs[3] = '{16'h0105, 4'b0000, 1'b1, 16'hFBDE, 32'hFF9F0349};
    vecs[4] = '{16'h8888, 4'b0100, 1'b0, 16'h7BDE, 32'h01000101};
    vecs[5] = '{16'h0003, 4'b0000, 1'b0, 16'h7BDE, 32'h0303030D};

    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.blank_lz = 1'b0;
    bus.en       = 1'b1;

    // Power-on reset held across edges.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_an", 32'(bus.an), 32'h0000000F);
    chk("reset_seg", 32'(bus.seg), 32'h000000FF);
    chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    edges = 0;
    mv    = '0;
    mdp   = '0;
    tick();
    chk("first_edge_an", 32'(bus.an), 32'h0000000E);

    // Vector table: one full frame per entry, checked slot by slot.
    for (int v = 0; v < 6; v++) begin
      bus.blank_lz = vecs[v].blz;
      load_word(vecs[v].value, vecs[v].dp);
      wait_frame();
      for (k = 0; k < FRAME; k++) begin
        tick();
        d = k / DIV;
        c = k % DIV;
        if (c < DIV - GAP) begin
          chk($sformatf("vec%0d_d%0d_an", v, d), 32'(bus.an), 32'(vecs[v].exp_an[4*d +: 4]));
          chk($sformatf("vec%0d_d%0d_seg", v, d), 32'(bus.seg), 32'(vecs[v].exp_seg[8*d +: 8]));
        end else begin
          chk($sformatf("vec%0d_d%0d_gap_an", v, d), 32'(bus.an), 32'h0000000F);
          chk($sformatf("vec%0d_d%0d_gap_seg", v, d), 32'(bus.seg), 32'h000000FF);
        end
      end
    end

    // Reset asserted during digit 2's DRIVE phase, between clock edges.
    bus.blank_lz = 1'b0;
    wait_frame();
    repeat (17) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midscan_reset_an", 32'(bus.an), 32'h0000000F);
    chk("midscan_reset_seg", 32'(bus.seg), 32'h000000FF);
    chk("midscan_reset_fd", 32'(bus.frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges = 0;
    mv    = '0;
    mdp   = '0;
    tick();
    chk("release_an", 32'(bus.an), 32'h0000000E);
    chk("release_seg", 32'(bus.seg), 32'h00000003);

    // Frame period and pulse width.
    wait_frame();
    period = 0;
    seen   = 1'b0;
    while (!seen && period < 2 * FRAME) begin
      tick();
      period++;
      seen = bus.frame_done;
    end
    chk("frame_period", 32'(period), 32'(FRAME));
    tick();
    chk("frame_width", 32'(bus.frame_done), 32'd0);

    // Mid-slot load during digit 0's DRIVE phase.
    load_word(16'h0003, 4'b0000);
    tick();
    chk("midload_seg", 32'(bus.seg), 32'h0000000D);

    // Display disabled: dark outputs, frame pulses continue.
    wait_frame();
    bus.en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      chk("disabled_an", 32'(bus.an), 32'h0000000F);
      chk("disabled_seg", 32'(bus.seg), 32'h000000FF);
      pulses += int'(bus.frame_done);
    end
    chk("disabled_pulses", 32'(pulses), 32'd2);
    bus.en = 1'b1;
    tick();
    chk("resume_an", 32'(bus.an), 32'h0000000B);

    // Randomized traffic; values often carry leading zeros to exercise blanking.
    for (int i = 0; i < 400; i++) begin
      bus.load     = ($urandom_range(0, 5) == 0);
      bus.value_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      bus.dp_in    = 4'($urandom);
      bus.blank_lz = 1'($urandom_range(0, 1));
      bus.en       = ($urandom_range(0, 9) != 0);
      tick();
    end
    bus.load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
